// File: rtl/onfi_pkg.sv
// rtl/onfi_pkg.sv - ONFI opcodes and target state encoding shared with controller blocks
package onfi_pkg;

  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_READ      = 8'h00;
  localparam logic [7:0] CMD_READ_CONF = 8'h30;
  localparam logic [7:0] CMD_READ_ID   = 8'h90;
  localparam logic [7:0] CMD_STATUS    = 8'h70;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_ADDR,
    ST_READ_CONF,
    ST_ID_ADDR,
    ST_BUSY
  } onfi_state_e;

endpackage

// File: rtl/onfi_latch_sampler.sv
// rtl/onfi_latch_sampler.sv - registers the ONFI bus and classifies WE# rising-edge latches
module onfi_latch_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen_i,
  input  logic       cle_i,
  input  logic       ale_i,
  input  logic       wen_i,
  input  logic [7:0] dq_i,
  output logic       cmd_strobe_o,
  output logic       addr_strobe_o,
  output logic       conflict_o,
  output logic [7:0] byte_o
);

  logic       cen_q;
  logic       cle_q;
  logic       ale_q;
  logic       wen_q;
  logic [7:0] dq_q;
  logic       latch;

  always_ff @(posedge clk) begin
    if (rst) begin
      cen_q <= 1'b1;
      cle_q <= 1'b0;
      ale_q <= 1'b0;
      wen_q <= 1'b1;
      dq_q  <= 8'h00;
    end else begin
      cen_q <= cen_i;
      cle_q <= cle_i;
      ale_q <= ale_i;
      wen_q <= wen_i;
      dq_q  <= dq_i;
    end
  end

  // Byte and latch enables come from the copy taken while WE# was still low.
  assign latch         = ~wen_q & wen_i & ~cen_q;
  assign cmd_strobe_o  = latch &  cle_q & ~ale_q;
  assign addr_strobe_o = latch & ~cle_q &  ale_q;
  assign conflict_o    = latch &  cle_q &  ale_q;
  assign byte_o        = dq_q;

endmodule

// File: rtl/onfi_target_decoder.sv
// rtl/onfi_target_decoder.sv - ONFI async target: command/address decode and ready/busy
module onfi_target_decoder
  import onfi_pkg::*;
#(
  parameter int DQ_W        = 32,
  parameter int ADDR_CYCLES = 5,
  parameter int T_RST       = 100,
  parameter int T_R         = 50
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     onfi_cen,
  input  logic                     onfi_cle,
  input  logic                     onfi_ale,
  input  logic                     onfi_wen,
  input  logic [DQ_W-1:0]          onfi_dq_i,
  output logic                     onfi_rbn,
  output logic                     cmd_valid,
  output logic [7:0]               cmd_code,
  output logic [8*ADDR_CYCLES-1:0] addr,
  output logic                     addr_valid,
  output logic                     id_req,
  output logic                     err
);

  localparam int TMAX   = (T_RST > T_R) ? T_RST : T_R;
  localparam int CNT_W  = $clog2(TMAX + 1);
  localparam int ACNT_W = $clog2(ADDR_CYCLES + 1);

  onfi_state_e              state_q, state_d;
  logic [CNT_W-1:0]         busy_q, busy_d;
  logic [ACNT_W-1:0]        acnt_q, acnt_d;
  logic [8*ADDR_CYCLES-1:0] addr_q, addr_d;
  logic [7:0]               code_q, code_d;
  logic                     cmd_valid_q, cmd_valid_d;
  logic                     addr_valid_q, addr_valid_d;
  logic                     id_req_q, id_req_d;
  logic                     err_q, err_d;

  logic       cmd_strobe;
  logic       addr_strobe;
  logic       conflict;
  logic [7:0] bus_byte;
  logic       unused_dq_hi;

  assign unused_dq_hi = ^onfi_dq_i[DQ_W-1:8];

  onfi_latch_sampler u_sampler (
    .clk          (clk),
    .rst          (rst),
    .cen_i        (onfi_cen),
    .cle_i        (onfi_cle),
    .ale_i        (onfi_ale),
    .wen_i        (onfi_wen),
    .dq_i         (onfi_dq_i[7:0]),
    .cmd_strobe_o (cmd_strobe),
    .addr_strobe_o(addr_strobe),
    .conflict_o   (conflict),
    .byte_o       (bus_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= '0;
      acnt_q       <= '0;
      addr_q       <= '0;
      code_q       <= 8'h00;
      cmd_valid_q  <= 1'b0;
      addr_valid_q <= 1'b0;
      id_req_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      acnt_q       <= acnt_d;
      addr_q       <= addr_d;
      code_q       <= code_d;
      cmd_valid_q  <= cmd_valid_d;
      addr_valid_q <= addr_valid_d;
      id_req_q     <= id_req_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    acnt_d       = acnt_q;
    addr_d       = addr_q;
    code_d       = code_q;
    cmd_valid_d  = 1'b0;
    addr_valid_d = 1'b0;
    id_req_d     = 1'b0;
    err_d        = 1'b0;

    // Busy countdown runs regardless of bus traffic; a latched FFh overrides it below.
    if (state_q == ST_BUSY) begin
      if (busy_q <= CNT_W'(1)) begin
        state_d = ST_IDLE;
        busy_d  = '0;
      end else begin
        busy_d = busy_q - CNT_W'(1);
      end
    end

    if (conflict) begin
      err_d = 1'b1;
    end else if (cmd_strobe) begin
      cmd_valid_d = 1'b1;
      code_d      = bus_byte;
      if (bus_byte == CMD_RESET) begin
        state_d = ST_BUSY;
        busy_d  = CNT_W'(T_RST);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus_byte == CMD_READ) begin
              state_d = ST_READ_ADDR;
              acnt_d  = '0;
            end else if (bus_byte == CMD_READ_ID) begin
              state_d = ST_ID_ADDR;
            end else begin
              cmd_valid_d = 1'b0;
              code_d      = code_q;
              err_d       = 1'b1;
            end
          end
          ST_READ_CONF: begin
            if (bus_byte == CMD_READ_CONF) begin
              state_d = ST_BUSY;
              busy_d  = CNT_W'(T_R);
            end else begin
              cmd_valid_d = 1'b0;
              code_d      = code_q;
              err_d       = 1'b1;
              state_d     = ST_IDLE;
            end
          end
          ST_BUSY: begin
            if (bus_byte != CMD_STATUS) begin
              cmd_valid_d = 1'b0;
              code_d      = code_q;
              err_d       = 1'b1;
            end
          end
          default: begin
            cmd_valid_d = 1'b0;
            code_d      = code_q;
            err_d       = 1'b1;
            state_d     = ST_IDLE;
          end
        endcase
      end
    end else if (addr_strobe) begin
      case (state_q)
        ST_READ_ADDR: begin
          addr_d[{acnt_q, 3'b000} +: 8] = bus_byte;
          if (acnt_q == ACNT_W'(ADDR_CYCLES - 1)) begin
            addr_valid_d = 1'b1;
            state_d      = ST_READ_CONF;
          end else begin
            acnt_d = acnt_q + ACNT_W'(1);
          end
        end
        ST_ID_ADDR: begin
          addr_d[7:0] = bus_byte;
          id_req_d    = 1'b1;
          state_d     = ST_IDLE;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  assign onfi_rbn   = (state_q != ST_BUSY);
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = code_q;
  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign id_req     = id_req_q;
  assign err        = err_q;

endmodule

// File: tb/tb_onfi_target_decoder.sv
// tb/tb_onfi_target_decoder.sv - self-checking bench for onfi_target_decoder
module tb_onfi_target_decoder;

  localparam int MAXC  = 30000;
  localparam int T_RST = 100;
  localparam int T_R   = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        onfi_cen = 1'b1;
  logic        onfi_cle = 1'b0;
  logic        onfi_ale = 1'b0;
  logic        onfi_wen = 1'b1;
  logic [31:0] onfi_dq = '0;
  logic        onfi_rbn, cmd_valid, addr_valid, id_req, err;
  logic [7:0]  cmd_code;
  logic [39:0] addr;

  onfi_target_decoder #(.DQ_W(32), .ADDR_CYCLES(5), .T_RST(T_RST), .T_R(T_R)) dut (
    .clk(clk), .rst(rst), .onfi_cen(onfi_cen), .onfi_cle(onfi_cle), .onfi_ale(onfi_ale),
    .onfi_wen(onfi_wen), .onfi_dq_i(onfi_dq), .onfi_rbn(onfi_rbn), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .addr(addr), .addr_valid(addr_valid), .id_req(id_req), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int last_edge = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: protocol phase, address bytes, and a per-cycle busy map.
  typedef enum int {M_IDLE, M_RADDR, M_RCONF, M_IDADDR} mode_e;
  typedef struct packed {
    bit          upd, cv, av, idr, er;
    logic [7:0]  code;
    logic [39:0] addr;
  } exp_t;

  exp_t       ex[MAXC];
  bit         busy_map[MAXC];
  mode_e      m_mode = M_IDLE;
  int         m_cnt = 0;
  logic [7:0] m_bytes[5];
  logic [7:0] m_code = 8'h00;

  function automatic logic [39:0] m_addr();
    logic [39:0] a = '0;
    for (int i = 0; i < 5; i++) a += 40'(m_bytes[i]) << (8 * i);
    return a;
  endfunction

  task automatic set_busy(input int from, input int len);
    for (int i = from; i < from + len && i < MAXC; i++) busy_map[i] = 1'b1;
  endtask

  task automatic model_edge(input int n, input bit cen_n, input bit c, input bit a, input logic [7:0] b);
    bit cv = 0, er = 0, av = 0, idr = 0;
    bit busy = busy_map[n];
    if (cen_n || (!c && !a)) return;
    if (c && a) er = 1;
    else if (c) begin
      if (b == 8'hFF) begin
        cv = 1; set_busy(n + 1, T_RST); m_mode = M_IDLE;
      end else if (busy) begin
        if (b == 8'h70) cv = 1; else er = 1;
      end else if (m_mode == M_IDLE && b == 8'h00) begin
        cv = 1; m_mode = M_RADDR; m_cnt = 0;
      end else if (m_mode == M_IDLE && b == 8'h90) begin
        cv = 1; m_mode = M_IDADDR;
      end else if (m_mode == M_RCONF && b == 8'h30) begin
        cv = 1; set_busy(n + 1, T_R); m_mode = M_IDLE;
      end else begin
        er = 1; m_mode = M_IDLE;
      end
      if (cv) m_code = b;
    end else begin
      if (busy) er = 1;
      else if (m_mode == M_RADDR) begin
        m_bytes[m_cnt] = b;
        m_cnt++;
        if (m_cnt == 5) begin av = 1; m_mode = M_RCONF; end
      end else if (m_mode == M_IDADDR) begin
        m_bytes[0] = b; idr = 1; m_mode = M_IDLE;
      end else er = 1;
    end
    if (n + 1 < MAXC) ex[n + 1] = '{upd: 1'b1, cv: cv, av: av, idr: idr, er: er, code: m_code, addr: m_addr()};
  endtask

  task automatic model_reset(input int r);
    for (int i = r + 1; i < MAXC; i++) busy_map[i] = 1'b0;
    m_mode = M_IDLE; m_cnt = 0; m_code = 8'h00;
    for (int i = 0; i < 5; i++) m_bytes[i] = 8'h00;
    ex[r + 1] = '{upd: 1'b1, cv: 1'b0, av: 1'b0, idr: 1'b0, er: 1'b0, code: 8'h00, addr: 40'h0};
  endtask

  // Per-cycle comparison of every output against the model.
  bit          chk_en = 0;
  logic [7:0]  cur_code = 8'h00;
  logic [39:0] cur_addr = '0;
  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      if (ex[cyc].upd) begin
        cur_code = ex[cyc].code;
        cur_addr = ex[cyc].addr;
      end
      check($sformatf("cycle%0d", cyc),
            64'({onfi_rbn, cmd_valid, addr_valid, id_req, err, cmd_code, addr}),
            64'({!busy_map[cyc], ex[cyc].cv, ex[cyc].av, ex[cyc].idr, ex[cyc].er, cur_code, cur_addr}));
    end
  end

  task automatic do_latch(input bit cen_n, input bit c, input bit a, input logic [7:0] b);
    logic [31:0] rnd = $urandom;
    @(posedge clk); #1;
    onfi_cen = cen_n; onfi_cle = c; onfi_ale = a; onfi_dq = {rnd[31:8], b}; onfi_wen = 1'b0;
    @(posedge clk); #1;
    onfi_wen = 1'b1;
    last_edge = cyc;
    model_edge(cyc, cen_n, c, a, b);
  endtask

  task automatic goto(input int k);
    while (cyc < k) begin @(posedge clk); #1; end
  endtask

  task automatic at_cycle(input int k);
    do @(negedge clk); while (cyc < k);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset(cyc);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit          cen_n, cle, ale;
    logic [7:0]  b;
    bit          cv, er, av, idr;
    logic [7:0]  code;
    logic [39:0] addr;
  } vec_t;
  vec_t vt[20];

  initial begin
    #(MAXC * 10);
    $display("FAIL timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int e, n0, r;
    for (int i = 0; i < MAXC; i++) begin ex[i] = '0; busy_map[i] = 1'b0; end
    for (int i = 0; i < 5; i++) m_bytes[i] = 8'h00;

    vt[0]  = '{0, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 40'h0};
    vt[1]  = '{0, 0, 1, 8'h11, 0, 0, 0, 0, 8'h00, 40'h11};
    vt[2]  = '{0, 0, 1, 8'h22, 0, 0, 0, 0, 8'h00, 40'h2211};
    vt[3]  = '{0, 0, 1, 8'h33, 0, 0, 0, 0, 8'h00, 40'h332211};
    vt[4]  = '{0, 0, 1, 8'h44, 0, 0, 0, 0, 8'h00, 40'h44332211};
    vt[5]  = '{0, 0, 1, 8'h55, 0, 0, 1, 0, 8'h00, 40'h5544332211};
    vt[6]  = '{0, 1, 0, 8'h70, 0, 1, 0, 0, 8'h00, 40'h5544332211};
    vt[7]  = '{0, 0, 1, 8'h12, 0, 1, 0, 0, 8'h00, 40'h5544332211};
    vt[8]  = '{0, 1, 0, 8'h90, 1, 0, 0, 0, 8'h90, 40'h5544332211};
    vt[9]  = '{0, 0, 1, 8'h00, 0, 0, 0, 1, 8'h90, 40'h5544332200};
    vt[10] = '{0, 1, 0, 8'h30, 0, 1, 0, 0, 8'h90, 40'h5544332200};
    vt[11] = '{0, 1, 1, 8'h00, 0, 1, 0, 0, 8'h90, 40'h5544332200};
    vt[12] = '{1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h90, 40'h5544332200};
    vt[13] = '{0, 0, 0, 8'hAA, 0, 0, 0, 0, 8'h90, 40'h5544332200};
    vt[14] = '{0, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 40'h5544332200};
    vt[15] = '{0, 1, 0, 8'h90, 0, 1, 0, 0, 8'h00, 40'h5544332200};
    vt[16] = '{0, 0, 1, 8'h77, 0, 1, 0, 0, 8'h00, 40'h5544332200};
    vt[17] = '{0, 1, 0, 8'h90, 1, 0, 0, 0, 8'h90, 40'h5544332200};
    vt[18] = '{0, 1, 1, 8'h90, 0, 1, 0, 0, 8'h90, 40'h5544332200};
    vt[19] = '{0, 0, 1, 8'h5A, 0, 0, 0, 1, 8'h90, 40'h554433225A};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1;
    @(negedge clk);
    check("reset", 64'({onfi_rbn, cmd_valid, addr_valid, id_req, err, cmd_code, addr}), 64'({1'b1, 52'h0}));

    for (int i = 0; i < 20; i++) begin
      do_latch(vt[i].cen_n, vt[i].cle, vt[i].ale, vt[i].b);
      at_cycle(last_edge + 1);
      check($sformatf("vec%0d", i),
            64'({onfi_rbn, cmd_valid, err, addr_valid, id_req, cmd_code, addr}),
            64'({1'b1, vt[i].cv, vt[i].er, vt[i].av, vt[i].idr, vt[i].code, vt[i].addr}));
    end

    // RESET: busy for exactly T_RST cycles
    do_latch(0, 1, 0, 8'hFF);
    e = last_edge;
    at_cycle(e + 1);
    check("rst_cmd", 64'({cmd_valid, cmd_code, onfi_rbn}), 64'({1'b1, 8'hFF, 1'b0}));
    at_cycle(e + T_RST);
    check("rst_busy_last", 64'(onfi_rbn), 64'(0));
    at_cycle(e + T_RST + 1);
    check("rst_ready", 64'(onfi_rbn), 64'(1));

    // READ with back-to-back address latches, then confirm
    do_latch(0, 1, 0, 8'h00);
    for (int i = 1; i <= 5; i++) do_latch(0, 0, 1, 8'(8'h11 * i));
    at_cycle(last_edge + 1);
    check("read_addr", 64'({addr_valid, addr}), 64'({1'b1, 40'h5544332211}));
    do_latch(0, 1, 0, 8'h30);
    e = last_edge;
    at_cycle(e + T_R);
    check("read_busy_last", 64'(onfi_rbn), 64'(0));
    at_cycle(e + T_R + 1);
    check("read_ready", 64'(onfi_rbn), 64'(1));

    // Commands during BUSY, then FFh reload at remaining=10
    do_latch(0, 1, 0, 8'hFF);
    n0 = last_edge;
    goto(n0 + 15);
    do_latch(0, 1, 0, 8'h80);
    at_cycle(last_edge + 1);
    check("busy_80", 64'({err, cmd_valid, cmd_code}), 64'({1'b1, 1'b0, 8'hFF}));
    do_latch(0, 1, 0, 8'h70);
    at_cycle(last_edge + 1);
    check("busy_70", 64'({err, cmd_valid, cmd_code}), 64'({1'b0, 1'b1, 8'h70}));
    goto(n0 + 89);
    do_latch(0, 1, 0, 8'hFF);
    e = last_edge;
    check("reload_pos", 64'(e), 64'(n0 + 91));
    at_cycle(n0 + T_RST + 1);
    check("reload_ext", 64'(onfi_rbn), 64'(0));
    at_cycle(e + T_RST);
    check("reload_last", 64'(onfi_rbn), 64'(0));
    at_cycle(e + T_RST + 1);
    check("reload_ready", 64'(onfi_rbn), 64'(1));

    // rst 20 cycles into a READ busy
    do_latch(0, 1, 0, 8'h00);
    for (int i = 1; i <= 5; i++) do_latch(0, 0, 1, 8'(8'h10 + i));
    do_latch(0, 1, 0, 8'h30);
    goto(last_edge + 19);
    apply_reset();
    r = cyc - 1;
    at_cycle(r + 1);
    check("rst_mid_busy", 64'({onfi_rbn, cmd_code, addr}), 64'({1'b1, 48'h0}));
    do_latch(0, 1, 0, 8'h00);
    at_cycle(last_edge + 1);
    check("post_rst_read", 64'({cmd_valid, cmd_code, err}), 64'({1'b1, 8'h00, 1'b0}));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int k = $urandom_range(0, 99);
      int s;
      logic [7:0] b = 8'($urandom);
      if (k < 45) begin
        s = $urandom_range(0, 19);
        if (s < 5) b = 8'h00;
        else if (s < 9) b = 8'h30;
        else if (s < 12) b = 8'h90;
        else if (s < 14) b = 8'h70;
        else if (s == 14) b = 8'hFF;
        do_latch(0, 1, 0, b);
      end else if (k < 85) do_latch(0, 0, 1, b);
      else if (k < 90) do_latch(0, 1, 1, b);
      else if (k < 95) do_latch(0, 0, 0, b);
      else do_latch(1, 1'($urandom), 1'($urandom), b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    while (cyc < MAXC - 2 && busy_map[cyc]) begin @(posedge clk); #1; end
    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/onfi_target_decoder.md
# onfi_target_decoder

NAND-side responder for the ONFI asynchronous command/address interface. It samples the controller-driven `onfi_cen/cle/ale/wen/dq` lines, decodes command and address latch cycles, tracks the RESET, READ (00h/30h) and READ ID (90h) sequences, and drives ready/busy. It is the target end of the bus driven by the `reset` command block and its siblings, and serves as the bus-functional NAND model in controller benches.

## Interface

**Parameters**
- `DQ_W`, 32: width of the DQ bus; only `dq[7:0]` carries command/address bytes.
- `ADDR_CYCLES`, 5: address cycles in a READ.
- `T_RST`, 100: busy cycles after RESET (FFh).
- `T_R`, 50: busy cycles after READ confirm (30h).

**Ports** (one clock; reset is synchronous and active-high)
- `clk`  in  1  system clock, shared with the controller.
- `rst`  in  1  synchronous active-high reset.
- `onfi_cen`  in  1  chip enable, active low.
- `onfi_cle`  in  1  command latch enable.
- `onfi_ale`  in  1  address latch enable.
- `onfi_wen`  in  1  write enable, active low; latch on rising edge.
- `onfi_dq_i`  in  DQ_W  DQ bus from the controller.
- `onfi_rbn`  out  1  ready/busy, 0 = busy.
- `cmd_valid`  out  1  one-cycle pulse per accepted command byte.
- `cmd_code`  out  8  last accepted command byte.
- `addr`  out  8*ADDR_CYCLES  assembled address, cycle 0 in bits [7:0].
- `addr_valid`  out  1  pulse when a READ address is complete.
- `id_req`  out  1  pulse when READ ID plus its 1 address cycle is complete.
- `err`  out  1  one-cycle protocol-error pulse.

## Operation

- Latch event: `onfi_wen` rising edge (registered 0, current 1) with registered `cen=0`. Byte, CLE and ALE come from the registered copies taken with `wen_q`.
- Latch classification:
  - CLE=1, ALE=0: command.
  - ALE=1, CLE=0: address.
  - Both 1: `err` pulse; state unchanged.
  - Both 0: data cycle; ignored.
- While `cen=1`, all edges are ignored.
- States: IDLE, READ_ADDR, READ_CONF, ID_ADDR, BUSY.
- Transitions:
  - IDLE + cmd 00h: clear address counter, go READ_ADDR.
  - IDLE + cmd 90h: go ID_ADDR.
  - IDLE + cmd FFh: go BUSY, load `T_RST`.
  - READ_ADDR: each address byte goes into slot `cnt`. On the `ADDR_CYCLES`th byte, pulse `addr_valid` and go READ_CONF.
  - READ_CONF + cmd 30h: go BUSY, load `T_R`.
  - ID_ADDR + address byte: pulse `id_req` and return to IDLE. The byte is stored in `addr[7:0]`.
  - BUSY: counter decrements each cycle. At 1, go IDLE and release `onfi_rbn`.
- Any other command outside BUSY (including 30h in IDLE, or a command during READ_ADDR) gives `err` and returns to IDLE. FFh is the exception: it always goes to BUSY with `T_RST`.
- Address byte in IDLE or READ_CONF: `err`, ignored.
- In BUSY:
  - FFh reloads the counter with `T_RST`.
  - 70h is accepted (`cmd_valid`) with no state change.
  - Any other command or address byte: `err`, ignored.
- `cmd_valid`/`cmd_code` update for every command byte that is not flagged `err`.
- Reset values:
  - `onfi_rbn`=1.
  - All pulses 0.
  - `cmd_code`=00h, `addr`=0, counters 0, state IDLE.
  - Registered `wen_q`=1, so no false edge after reset.

## Timing

- Edge first seen high in cycle N: `cmd_valid`, `addr_valid`, `id_req` and `err` pulse in cycle N+1.
- Entering BUSY: `onfi_rbn` falls in cycle N+1.
- After a BUSY entry with load `T`, `onfi_rbn` stays 0 for exactly `T` cycles (N+1 … N+T) and is 1 at N+T+1.
- Minimum legal WE# low/high width: 1 clock each. Back-to-back latches every 2 cycles must all be captured.
- `rst` asserted in any state, including mid-BUSY: all outputs take reset values in the next cycle.

## Structure

- Package `onfi_pkg` holds:
  - opcodes `CMD_RESET`=FFh, `CMD_READ`=00h, `CMD_READ_CONF`=30h, `CMD_READ_ID`=90h, `CMD_STATUS`=70h;
  - the state enum;
  - shared with controller blocks.
- Sub-module `onfi_latch_sampler` registers the inputs, detects WE# rising edges and emits `cmd_strobe`/`addr_strobe`/`conflict` with the byte. The decoder FSM sits above it.

## Test plan

- Reset: CLE=1, dq=FFh, one WE# pulse → `cmd_valid` with FFh; `onfi_rbn` 0 for exactly 100 cycles, then 1.
- Read: 00h, address bytes 11h/22h/33h/44h/55h, then 30h → `addr`=55_4433_2211h, `addr_valid` once; `onfi_rbn` low for 50 cycles.
- Read ID: 90h then address 00h → `id_req` pulse one cycle after the address edge; `onfi_rbn` stays 1.
- During BUSY: cmd 80h → `err`, counter unaffected. FFh at remaining=10 → busy extends to 100 cycles from that edge. 70h → `cmd_valid`, no `err`.
- Conflict and deselect: CLE=ALE=1 edge → `err`, state kept. Edges with `cen`=1 → no outputs at all.
- Apply `rst` 20 cycles into a READ BUSY → `onfi_rbn`=1 next cycle. A fresh 00h then decodes normally.
